// File: rtl/hazard_pkg.sv
// Shared types for the hazard sequencer: FSM encoding, pipeline control bundle
// and the load-use / hazard-priority decode used by the top level.
package hazard_pkg;

   localparam int REG_W = 5;
   localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

   typedef enum logic [1:0] {
      S_RUN      = 2'd0,
      S_MEM_WAIT = 2'd1,
      S_MEM_ERR  = 2'd2
   } state_e;

   typedef struct packed {
      logic pc_we;
      logic ifid_we;
      logic ifid_flush;
      logic idex_we;
      logic idex_bubble;
      logic exmem_we;
      logic memwb_bubble;
   } pipe_ctl_t;

   localparam pipe_ctl_t CTL_RESET = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b0,
                                       idex_we: 1'b0, idex_bubble: 1'b1, exmem_we: 1'b0,
                                       memwb_bubble: 1'b1};
   localparam pipe_ctl_t CTL_FROZEN = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b0,
                                        idex_we: 1'b0, idex_bubble: 1'b0, exmem_we: 1'b0,
                                        memwb_bubble: 1'b1};
   localparam pipe_ctl_t CTL_RUN = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b0,
                                     idex_we: 1'b1, idex_bubble: 1'b0, exmem_we: 1'b1,
                                     memwb_bubble: 1'b0};

   function automatic logic load_use(input logic             ex_mem_read,
                                     input logic [REG_W-1:0] ex_rt,
                                     input logic [REG_W-1:0] id_rs,
                                     input logic [REG_W-1:0] id_rt,
                                     input logic             id_uses_rt);
      return ex_mem_read && (ex_rt != ZERO_REG) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
   endfunction

   // A taken branch squashes whatever is in ID, so it outranks load-use and jump.
   function automatic pipe_ctl_t advance_ctl(input logic branch, input logic lu,
                                             input logic jump);
      pipe_ctl_t c;
      c = CTL_RUN;
      if (branch) begin
         c.ifid_flush  = 1'b1;
         c.idex_bubble = 1'b1;
      end else if (lu) begin
         c.pc_we       = 1'b0;
         c.ifid_we     = 1'b0;
         c.idex_bubble = 1'b1;
      end else if (jump) begin
         c.ifid_flush  = 1'b1;
      end
      return c;
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating count of consecutive data-memory wait cycles; flags when the
// count has reached MEM_TIMEOUT (never flags when MEM_TIMEOUT is 0).
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic timeout
);

   localparam int TW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [TW-1:0] LIMIT = TW'(MEM_TIMEOUT);

   logic [TW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + TW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign timeout = (MEM_TIMEOUT != 0) && (cnt_q >= LIMIT);

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline sequencing controller: load-use stalls, branch/jump flushes and
// data-memory waits with timeout. Define HAZ_STALL_CNT_EN to build the stall counter.
module hazard_sequencer
   import hazard_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             id_jump,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rt,
   input  logic             ex_branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_we,
   output logic             ifid_we,
   output logic             ifid_flush,
   output logic             idex_we,
   output logic             idex_bubble,
   output logic             exmem_we,
   output logic             memwb_bubble,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt
);

   state_e    state_q, state_d;
   logic      live_q, live_d;
   logic      lu, mem_blocked;
   logic      tmr_clr, tmr_inc, tmr_timeout;
   pipe_ctl_t ctl;

   // mem_req/mem_ready: an access in MEM completes in the first cycle where both
   // are high; until then the whole pipeline holds. Dropping mem_req abandons it.
   assign mem_blocked = mem_req && !mem_ready;
   assign lu          = load_use(ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rt);

   always_comb begin
      live_d  = 1'b1;
      ctl     = CTL_RESET;
      state_d = state_q;
      mem_err = 1'b0;
      tmr_clr = 1'b1;
      tmr_inc = 1'b0;
      if (live_q) begin
         case (state_q)
            S_RUN, S_MEM_WAIT: begin
               if (mem_blocked) begin
                  ctl     = CTL_FROZEN;
                  tmr_clr = 1'b0;
                  if ((state_q == S_MEM_WAIT) && tmr_timeout) begin
                     state_d = S_MEM_ERR;
                  end else begin
                     state_d = S_MEM_WAIT;
                     tmr_inc = 1'b1;
                  end
               end else begin
                  ctl     = advance_ctl(ex_branch_taken, lu, id_jump);
                  state_d = S_RUN;
               end
            end
            S_MEM_ERR: begin
               ctl     = CTL_FROZEN;
               mem_err = 1'b1;
               tmr_clr = 1'b0;
            end
            default: state_d = S_RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_RUN;
         live_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         live_q  <= live_d;
      end
   end

   mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (tmr_clr),
      .inc     (tmr_inc),
      .timeout (tmr_timeout)
   );

   assign pc_we        = ctl.pc_we;
   assign ifid_we      = ctl.ifid_we;
   assign ifid_flush   = ctl.ifid_flush;
   assign idex_we      = ctl.idex_we;
   assign idex_bubble  = ctl.idex_bubble;
   assign exmem_we     = ctl.exmem_we;
   assign memwb_bubble = ctl.memwb_bubble;

`ifdef HAZ_STALL_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (live_q && !ctl.pc_we && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: directed scenarios plus a random
// run against a cycle-level behavioural model. Two instances: default and MEM_TIMEOUT=3.
module tb_hazard_sequencer;

   localparam int CNT_W = 32;
   localparam int TO_A  = 15;

   // Control vector order: {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_bubble}
   localparam logic [6:0] RESET_CTL  = 7'b0000101;
   localparam logic [6:0] FROZEN_CTL = 7'b0000001;
   localparam logic [6:0] NORMAL_CTL = 7'b1101010;
   localparam logic [6:0] BRANCH_CTL = 7'b1111110;
   localparam logic [6:0] LU_CTL     = 7'b0001110;
   localparam logic [6:0] JUMP_CTL   = 7'b1111010;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [4:0] id_rs, id_rt, ex_rt;
   logic id_uses_rt, id_jump, ex_mem_read, ex_branch_taken, mem_req, mem_ready;

   logic pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_bubble, mem_err;
   logic [CNT_W-1:0] stall_cnt;
   logic t_pc_we, t_ifid_we, t_ifid_flush, t_idex_we, t_idex_bubble, t_exmem_we;
   logic t_memwb_bubble, t_mem_err;
   logic [CNT_W-1:0] t_stall_cnt;

   logic [6:0] ctl_obs, t_ctl_obs;
   assign ctl_obs   = {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_bubble};
   assign t_ctl_obs = {t_pc_we, t_ifid_we, t_ifid_flush, t_idex_we, t_idex_bubble, t_exmem_we,
                       t_memwb_bubble};

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   hazard_sequencer #(.MEM_TIMEOUT(TO_A), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .id_jump(id_jump), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
      .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_we(idex_we),
      .idex_bubble(idex_bubble), .exmem_we(exmem_we), .memwb_bubble(memwb_bubble),
      .mem_err(mem_err), .stall_cnt(stall_cnt)
   );

   hazard_sequencer #(.MEM_TIMEOUT(3), .CNT_W(CNT_W)) dut_to (
      .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .id_jump(id_jump), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
      .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_we(t_pc_we), .ifid_we(t_ifid_we), .ifid_flush(t_ifid_flush), .idex_we(t_idex_we),
      .idex_bubble(t_idex_bubble), .exmem_we(t_exmem_we), .memwb_bubble(t_memwb_bubble),
      .mem_err(t_mem_err), .stall_cnt(t_stall_cnt)
   );

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
      id_uses_rt = 1'b0; id_jump = 1'b0; ex_mem_read = 1'b0;
      ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Holds reset three cycles, releases, and steps past the edge that sets live.
   task automatic reset_dut();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      next_cycle();
   endtask

   function automatic logic [31:0] exp_stalls(input int model_count);
`ifdef HAZ_STALL_CNT_EN
      return 32'(model_count);
`else
      return 32'd0 + 32'(model_count * 0);
`endif
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      idle_inputs();
      @(posedge clk); #1 rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (ctl_obs !== RESET_CTL || mem_err !== 1'b0)
            $display("FAIL reset_hold[%0d]: got ctl=%b err=%b want ctl=%b err=0", i, ctl_obs, mem_err, RESET_CTL);
         else n_pass++;
         @(posedge clk);
      end
      #1 rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (ctl_obs !== RESET_CTL)
         $display("FAIL reset_first_cycle: got ctl=%b want %b", ctl_obs, RESET_CTL);
      else n_pass++;
      n_checks++;
      if (stall_cnt !== 32'd0)
         $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
      else n_pass++;
      next_cycle();
      @(negedge clk);
      n_checks++;
      if (ctl_obs !== NORMAL_CTL || mem_err !== 1'b0)
         $display("FAIL reset_live: got ctl=%b err=%b want ctl=%b err=0", ctl_obs, mem_err, NORMAL_CTL);
      else n_pass++;
      next_cycle();
   endtask

   task automatic test_load_use();
      idle_inputs();
      ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
      @(negedge clk);
      n_checks++;
      if (ctl_obs !== LU_CTL) $display("FAIL lu_rs: got %b want %b", ctl_obs, LU_CTL);
      else n_pass++;
      next_cycle();
      ex_mem_read = 1'b0; ex_rt = 5'd0;
      @(negedge clk);
      n_checks++;
      if (ctl_obs !== NORMAL_CTL) $display("FAIL lu_release: got %b want %b", ctl_obs, NORMAL_CTL);
      else n_pass++;
      next_cycle();
      ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
      @(negedge clk);
      n_checks++;
      if (ctl_obs !== NORMAL_CTL) $display("FAIL lu_zero_reg: got %b want %b", ctl_obs, NORMAL_CTL);
      else n_pass++;
      next_cycle();
      ex_rt = 5'd5; id_rt = 5'd5; id_rs = 5'd1; id_uses_rt = 1'b0;
      @(negedge clk);
      n_checks++;
      if (ctl_obs !== NORMAL_CTL) $display("FAIL lu_rt_unused: got %b want %b", ctl_obs, NORMAL_CTL);
      else n_pass++;
      next_cycle();
      id_uses_rt = 1'b1;
      @(negedge clk);
      n_checks++;
      if (ctl_obs !== LU_CTL) $display("FAIL lu_rt: got %b want %b", ctl_obs, LU_CTL);
      else n_pass++;
      next_cycle();
      idle_inputs();
   endtask

   task automatic test_branch_vs_lu();
      idle_inputs();
      ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd9; id_rt = 5'd9;
      id_uses_rt = 1'b1; id_jump = 1'b1;
      @(negedge clk);
      n_checks++;
      if (ctl_obs !== BRANCH_CTL) $display("FAIL branch_over_lu: got %b want %b", ctl_obs, BRANCH_CTL);
      else n_pass++;
      next_cycle();
      idle_inputs();
   endtask

   task automatic test_jump_lu();
      idle_inputs();
      id_jump = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
      @(negedge clk);
      n_checks++;
      if (ctl_obs !== LU_CTL) $display("FAIL jump_lu_stall: got %b want %b", ctl_obs, LU_CTL);
      else n_pass++;
      next_cycle();
      ex_mem_read = 1'b0;
      @(negedge clk);
      n_checks++;
      if (ctl_obs !== JUMP_CTL) $display("FAIL jump_flush: got %b want %b", ctl_obs, JUMP_CTL);
      else n_pass++;
      next_cycle();
      idle_inputs();
   endtask

   task automatic test_mem_wait();
      idle_inputs();
      reset_dut();
      mem_req = 1'b1; mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_checks++;
         if (ctl_obs !== FROZEN_CTL || mem_err !== 1'b0)
            $display("FAIL mem_wait_frozen[%0d]: got ctl=%b err=%b want ctl=%b err=0", i, ctl_obs, mem_err, FROZEN_CTL);
         else n_pass++;
         next_cycle();
      end
      mem_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (ctl_obs !== NORMAL_CTL) $display("FAIL mem_advance: got %b want %b", ctl_obs, NORMAL_CTL);
      else n_pass++;
      next_cycle();
      idle_inputs();
      @(negedge clk);
      n_checks++;
      if (stall_cnt !== exp_stalls(4)) $display("FAIL mem_stall_cnt: got %0d want %0d", stall_cnt, exp_stalls(4));
      else n_pass++;
      next_cycle();
      // One blocked cycle, then mem_req drops with a taken branch: access abandoned.
      mem_req = 1'b1; mem_ready = 1'b0;
      next_cycle();
      mem_req = 1'b0; ex_branch_taken = 1'b1;
      @(negedge clk);
      n_checks++;
      if (ctl_obs !== BRANCH_CTL) $display("FAIL wait_abandon_branch: got %b want %b", ctl_obs, BRANCH_CTL);
      else n_pass++;
      next_cycle();
      idle_inputs();
      @(negedge clk);
      n_checks++;
      if (ctl_obs !== NORMAL_CTL) $display("FAIL wait_abandon_run: got %b want %b", ctl_obs, NORMAL_CTL);
      else n_pass++;
      next_cycle();
   endtask

   task automatic test_timeout();
      idle_inputs();
      // Start a wait, then pull reset mid-wait; the next wait must start from zero.
      mem_req = 1'b1; mem_ready = 1'b0;
      next_cycle();
      next_cycle();
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (t_ctl_obs !== RESET_CTL || ctl_obs !== RESET_CTL)
         $display("FAIL reset_mid_wait: got ctl=%b/%b want %b", ctl_obs, t_ctl_obs, RESET_CTL);
      else n_pass++;
      reset_dut();
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         n_checks++;
         if (t_ctl_obs !== FROZEN_CTL || t_mem_err !== (i == 5))
            $display("FAIL timeout_cycle[%0d]: got ctl=%b err=%b want ctl=%b err=%b", i, t_ctl_obs, t_mem_err, FROZEN_CTL, (i == 5));
         else n_pass++;
         next_cycle();
      end
      mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (t_ctl_obs !== FROZEN_CTL || t_mem_err !== 1'b1)
            $display("FAIL timeout_sticky[%0d]: got ctl=%b err=%b want ctl=%b err=1", i, t_ctl_obs, t_mem_err, FROZEN_CTL);
         else n_pass++;
         if (i == 0) begin
            n_checks++;
            if (ctl_obs !== NORMAL_CTL || mem_err !== 1'b0)
               $display("FAIL long_wait_advance: got ctl=%b err=%b want ctl=%b err=0", ctl_obs, mem_err, NORMAL_CTL);
            else n_pass++;
         end
         next_cycle();
      end
      idle_inputs();
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (t_mem_err !== 1'b0) $display("FAIL timeout_reset_clear: got %b want 0", t_mem_err);
      else n_pass++;
      reset_dut();
      @(negedge clk);
      n_checks++;
      if (t_ctl_obs !== NORMAL_CTL || t_mem_err !== 1'b0)
         $display("FAIL timeout_recover: got ctl=%b err=%b want ctl=%b err=0", t_ctl_obs, t_mem_err, NORMAL_CTL);
      else n_pass++;
      next_cycle();
   endtask

   // Behavioural reference: one cycle's expected {mem_err, ctl} from the hazard rules.
   function automatic logic [7:0] model_expect(input bit errored, input bit blocked,
                                               input bit branch, input bit lu, input bit jump);
      if (errored) return {1'b1, FROZEN_CTL};
      if (blocked) return {1'b0, FROZEN_CTL};
      if (branch)  return {1'b0, BRANCH_CTL};
      if (lu)      return {1'b0, LU_CTL};
      if (jump)    return {1'b0, JUMP_CTL};
      return {1'b0, NORMAL_CTL};
   endfunction

   task automatic test_random();
      bit m_errored = 1'b0;
      bit m_waiting = 1'b0;
      int m_waited  = 0;
      int m_stalls  = 0;
      int errs      = 0;
      bit lu_now, blocked;
      logic [7:0] exp_v;
      idle_inputs();
      reset_dut();
      for (int i = 0; i < 400; i++) begin
         id_rs           = 5'($urandom_range(0, 3));
         id_rt           = 5'($urandom_range(0, 3));
         ex_rt           = 5'($urandom_range(0, 3));
         id_uses_rt      = 1'($urandom_range(0, 1));
         ex_mem_read     = 1'($urandom_range(0, 1));
         ex_branch_taken = ($urandom_range(0, 4) == 0);
         id_jump         = ($urandom_range(0, 4) == 0);
         mem_req         = ($urandom_range(0, 4) < 2);
         mem_ready       = ((i / 100) == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
         lu_now  = ex_mem_read && (ex_rt != 0) &&
                   ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
         blocked = mem_req && !mem_ready;
         exp_v   = model_expect(m_errored, blocked, ex_branch_taken, lu_now, id_jump);
         @(negedge clk);
         n_checks++;
         if ({mem_err, ctl_obs} !== exp_v) begin
            if (errs < 10)
               $display("FAIL random[%0d]: got err,ctl=%b want %b", i, {mem_err, ctl_obs}, exp_v);
            errs++;
         end else n_pass++;
         if (!exp_v[6]) m_stalls++;
         if (!m_errored) begin
            if (blocked) begin
               if (m_waiting && m_waited >= TO_A) m_errored = 1'b1;
               else begin
                  m_waiting = 1'b1;
                  m_waited++;
               end
            end else begin
               m_waiting = 1'b0;
               m_waited  = 0;
            end
         end
         next_cycle();
      end
      n_checks++;
      if (stall_cnt !== exp_stalls(m_stalls))
         $display("FAIL random_stall_cnt: got %0d want %0d", stall_cnt, exp_stalls(m_stalls));
      else n_pass++;
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_load_use();
      test_branch_vs_lu();
      test_jump_lu();
      test_mem_wait();
      test_timeout();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
